// File: rtl/am2910_pkg.sv
// Shared constants for the am2910 slice: default geometry of the micro-program stack
// and the operation selected on each clock edge.
package am2910_pkg;

  localparam int unsigned MPSTACK_WIDTH = 12;
  localparam int unsigned MPSTACK_DEPTH = 8;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_CLEAR,
    OP_REPLACE,
    OP_PUSH,
    OP_POP
  } mpstack_op_e;

endpackage

// File: rtl/mpstack_mem.sv
// Stack storage: one synchronous write port, one asynchronous read port, no reset.
module mpstack_mem #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mpstack.sv
// Micro-program stack with registered top-of-stack, entry count and sticky
// overflow/underflow flags; storage lives in mpstack_mem.
module mpstack
  import am2910_pkg::*;
#(
  parameter int unsigned WIDTH = MPSTACK_WIDTH,
  parameter int unsigned DEPTH = MPSTACK_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           tos,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf,
  output logic                       udf
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  mpstack_op_e      op;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] tos_nxt;
  logic             set_ovf, set_udf;
  logic             we;
  logic [AW-1:0]    waddr, raddr;
  logic [WIDTH-1:0] rdata;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Entry below the top, used when a pop leaves at least one entry behind.
  assign raddr = AW'(count - CW'(2));

  always_comb begin
    op = OP_IDLE;
    if (clear)            op = OP_CLEAR;
    else if (push && pop) op = OP_REPLACE;
    else if (push)        op = OP_PUSH;
    else if (pop)         op = OP_POP;
  end

  always_comb begin
    count_nxt = count;
    tos_nxt   = tos;
    set_ovf   = 1'b0;
    set_udf   = 1'b0;
    we        = 1'b0;
    waddr     = AW'(count);
    unique case (op)
      OP_CLEAR: begin
        count_nxt = '0;
        tos_nxt   = '0;
      end
      OP_REPLACE: begin
        // Replace on an empty stack degenerates to a plain push into entry 0.
        we      = 1'b1;
        tos_nxt = din;
        if (empty) begin
          waddr     = '0;
          count_nxt = CW'(1);
        end else begin
          waddr = AW'(count - CW'(1));
        end
      end
      OP_PUSH: begin
        if (full) begin
          set_ovf = 1'b1;
        end else begin
          we        = 1'b1;
          count_nxt = count + CW'(1);
          tos_nxt   = din;
        end
      end
      OP_POP: begin
        if (empty) begin
          set_udf = 1'b1;
        end else begin
          count_nxt = count - CW'(1);
          tos_nxt   = (count == CW'(1)) ? '0 : rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tos   <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      count <= count_nxt;
      tos   <= tos_nxt;
      if (set_ovf) ovf <= 1'b1;
      if (set_udf) udf <= 1'b1;
    end
  end

  mpstack_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(din),
    .raddr(raddr),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_mpstack.sv
// Directed self-checking bench for mpstack at default geometry (12 x 8).
module tb_mpstack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear, push, pop;
  logic [11:0] din;
  logic [11:0] tos;
  logic [3:0]  count;
  logic        empty, full, ovf, udf;

  int checks = 0;
  int errors = 0;

  mpstack dut (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .push (push),
    .pop  (pop),
    .din  (din),
    .tos  (tos),
    .count(count),
    .empty(empty),
    .full (full),
    .ovf  (ovf),
    .udf  (udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [11:0] e_tos, input logic [3:0] e_cnt,
                           input logic e_empty, input logic e_full, input logic e_ovf,
                           input logic e_udf);
    chk({tag, ".tos"},   32'(tos),   32'(e_tos));
    chk({tag, ".count"}, 32'(count), 32'(e_cnt));
    chk({tag, ".empty"}, 32'(empty), 32'(e_empty));
    chk({tag, ".full"},  32'(full),  32'(e_full));
    chk({tag, ".ovf"},   32'(ovf),   32'(e_ovf));
    chk({tag, ".udf"},   32'(udf),   32'(e_udf));
  endtask

  // Drive one operation for a single edge; outputs are sampled 1 time unit later.
  task automatic op(input logic c, input logic pu, input logic po, input logic [11:0] d);
    clear = c; push = pu; pop = po; din = d;
    @(posedge clk); #1;
    clear = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
    #2;
    chk_state("reset", 12'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Underflow is sticky and survives clear
    op(1'b0, 1'b0, 1'b1, 12'h000);
    chk_state("pop_empty", 12'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    op(1'b1, 1'b0, 1'b0, 12'h000);
    chk_state("clear_keeps_udf", 12'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    do_reset();
    chk_state("reset2", 12'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Basic push / pop ordering
    op(1'b0, 1'b1, 1'b0, 12'h111);
    chk_state("push1", 12'h111, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    op(1'b0, 1'b1, 1'b0, 12'h222);
    op(1'b0, 1'b1, 1'b0, 12'h333);
    chk_state("push3", 12'h333, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    op(1'b0, 1'b0, 1'b1, 12'h000);
    chk_state("pop_a", 12'h222, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    op(1'b0, 1'b0, 1'b1, 12'h000);
    chk_state("pop_b", 12'h111, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    op(1'b0, 1'b0, 1'b1, 12'h000);
    chk_state("pop_c", 12'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Replace (push+pop)
    op(1'b0, 1'b1, 1'b0, 12'h0A0);
    op(1'b0, 1'b1, 1'b1, 12'h5A5);
    chk_state("replace", 12'h5A5, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    op(1'b0, 1'b0, 1'b1, 12'h000);
    chk_state("replace_pop", 12'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    op(1'b0, 1'b1, 1'b1, 12'h123);
    chk_state("replace_empty", 12'h123, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    op(1'b0, 1'b0, 1'b1, 12'h000);
    chk_state("replace_empty_pop", 12'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Fill, overflow, replace when full, then walk down
    for (int i = 1; i <= 8; i++) op(1'b0, 1'b1, 1'b0, 12'h800 + 12'(i));
    chk_state("full", 12'h808, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0);
    op(1'b0, 1'b1, 1'b0, 12'hFFF);
    chk_state("overflow", 12'h808, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0);
    op(1'b0, 1'b1, 1'b1, 12'h777);
    chk_state("replace_full", 12'h777, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0);
    op(1'b0, 1'b0, 1'b1, 12'h000);
    chk_state("pop_after_full", 12'h807, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    op(1'b0, 1'b0, 1'b1, 12'h000);
    op(1'b0, 1'b0, 1'b1, 12'h000);
    op(1'b0, 1'b0, 1'b1, 12'h000);
    chk_state("count4", 12'h804, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);

    // Clear wins over a simultaneous push; ovf survives clear
    op(1'b1, 1'b1, 1'b0, 12'hABC);
    chk_state("clear_push", 12'h000, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset while a push is held
    op(1'b0, 1'b1, 1'b0, 12'h321);
    chk_state("pre_async", 12'h321, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    push = 1'b1; din = 12'h456;
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", 12'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_state("held_rst", 12'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    push = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_state("post_rst_idle", 12'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    op(1'b0, 1'b1, 1'b0, 12'h999);
    chk_state("first_op", 12'h999, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    op(1'b0, 1'b1, 1'b0, 12'hAAA);
    op(1'b0, 1'b0, 1'b1, 12'h000);
    chk_state("first_op_pop", 12'h999, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpstack.md
MPSTACK -- requirements
Module: mpstack

Interface
REQ-001 Parameter WIDTH, default 12: data word width in bits, SHALL be >= 1.
REQ-002 Parameter DEPTH, default 8: number of stack entries, SHALL be >= 2; need not be a power of two.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 clear  input  1  synchronous empty-the-stack request.
REQ-006 push  input  1  push din.
REQ-007 pop  input  1  pop top entry.
REQ-008 din  input  WIDTH  data to push.
REQ-009 tos  output  WIDTH  registered top-of-stack value.
REQ-010 count  output  $clog2(DEPTH+1)  registered number of valid entries.
REQ-011 empty  output  1  high when count==0.
REQ-012 full  output  1  high when count==DEPTH.
REQ-013 ovf  output  1  sticky overflow error.
REQ-014 udf  output  1  sticky underflow error.

Function
REQ-015 Operation priority SHALL be: clear, then push+pop (replace), then push, then pop, then idle.
REQ-016 clear SHALL set count=0 and tos=0; ovf, udf and array contents are unchanged.
REQ-017 Push when not full SHALL write din to entry[count], increment count, and set tos=din, all in the same edge.
REQ-018 Pop when count>=2 SHALL decrement count and set tos=entry[count-2].
REQ-019 Pop when count==1 SHALL set count=0 and tos=0.
REQ-020 Push+pop when count>=1 SHALL overwrite entry[count-1] with din, keep count, and set tos=din.
REQ-021 Push+pop when empty SHALL act as a plain push: count=1, tos=din.
REQ-022 Push (without pop) when full SHALL leave count, array and tos unchanged, and set ovf=1.
REQ-023 Pop (without push) when empty SHALL leave state unchanged and set udf=1.
REQ-024 ovf and udf SHALL clear only on reset.
REQ-025 Latency: tos, count, empty and full SHALL reflect an operation on the first rising edge after it is sampled; there is no combinational input-to-output path.
REQ-026 empty and full SHALL be registered or derived from the count register only.
REQ-027 Array entries at index >= count are don't-care and SHALL never drive tos.

Reset
REQ-028 rst_n low SHALL immediately force count=0, tos=0, empty=1, full=0, ovf=0, udf=0, regardless of clk.
REQ-029 Array contents SHALL NOT be reset; they remain unconstrained after reset.
REQ-030 Reset asserted mid-operation SHALL abort that operation, with no partial state visible after release.
REQ-031 The first operation SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-032 Default WIDTH and DEPTH constants SHALL live in the shared am2910_pkg package; no typedefs are required.
REQ-033 Storage SHALL be one sub-module, mpstack_mem: a WIDTH x DEPTH array with one synchronous write port and one asynchronous read port, no reset.
REQ-034 mpstack SHALL hold the count, tos, flag and priority logic and instantiate mpstack_mem once.

Verification
REQ-035 Reset, then push 0x111, 0x222, 0x333 -> tos=0x333, count=3; three pops -> tos=0x222, then 0x111, then 0, with empty=1.
REQ-036 DEPTH=8: push 8 words -> full=1; a 9th push of 0xFFF -> ovf=1, tos still holds the 8th word, count=8.
REQ-037 Pop on empty after reset -> udf=1, count=0, tos=0; clear does not clear udf.
REQ-038 Push 0x0A0, then push+pop with din=0x5A5 -> count=1, tos=0x5A5; pop -> empty=1; push+pop when empty with 0x123 -> count=1, tos=0x123.
REQ-039 Stack with count=4, assert clear together with push -> count=0, tos=0, empty=1 on the next edge.
REQ-040 Assert rst_n low between clock edges while a push is held -> outputs go to reset values at once, and no push is recorded after release.
